// File: rtl/spi_target_shift_reg.sv
// spi_target_shift_reg: SPI mode-0 target with oversampled pins, parallel rx word and buffered tx word
module spi_target_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] FILL = {WIDTH{1'b1}}
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             sclk_in,
  input  logic             cs_n_in,
  input  logic             mosi_in,
  output logic             miso_out,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic             tx_underrun
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nxt;
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic [CW-1:0] bit_cnt;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] tx_shift, tx_buf, rx_word;
  logic tx_pending, reload_pend;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s, sel;
  logic xfer, shl, rx_take, abort, word_done;
  // [0],[1] are the two sync stages, [2] is the edge-detect history
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_in};
      cs_q   <= {cs_q[1:0], cs_n_in};
      mosi_q <= {mosi_q[0], mosi_in};
    end
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign mosi_s    = mosi_q[1];
  assign sel       = ~cs_q[1];
  assign miso_oe   = sel;
  assign miso_out  = sel & tx_shift[WIDTH-1];
  assign tx_ready  = ~tx_pending;
  assign rx_word   = {rx_shift, mosi_s};
  assign word_done = rx_take && bit_cnt == LAST;
  // state register
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // next state and per-cycle actions; a cs_n rise overrides any sclk edge
  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    shl       = 1'b0;
    rx_take   = 1'b0;
    abort     = 1'b0;
    if (cs_rise) begin
      state_nxt = IDLE;
      abort     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = cs_fall ? LOAD : IDLE;
          xfer      = cs_fall;
        end
        LOAD: state_nxt = SHIFT;
        default: begin
          rx_take = sclk_rise;
          xfer    = sclk_fall & reload_pend;
          shl     = sclk_fall & ~reload_pend;
        end
      endcase
    end
  end
  // datapath: shift registers, word counter, tx buffer handshake, strobes
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      tx_pending  <= 1'b0;
      tx_underrun <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      rx_valid    <= word_done;
      tx_underrun <= xfer & ~tx_pending;
      tx_pending  <= tx_pending ? ~xfer : tx_load;
      if (tx_load && !tx_pending) tx_buf <= tx_data;
      if (xfer) tx_shift <= tx_pending ? tx_buf : FILL;
      else if (shl) tx_shift <= tx_shift << 1;
      if (rx_take) rx_shift <= rx_word[WIDTH-2:0];
      if (word_done) rx_data <= rx_word;
      if (abort || state == IDLE) bit_cnt <= '0;
      else if (rx_take) bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      reload_pend <= abort ? 1'b0 : word_done ? 1'b1 : xfer ? 1'b0 : reload_pend;
    end
endmodule
